// File: rtl/alu_shifter_seq.sv
// rtl/alu_shifter_seq.sv - handshaked ALU with iterative one-bit-per-cycle shifter and registered SZCV flags
module alu_shifter_seq #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shift_d,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic [3:0]       szcv
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_CMP = 4'b0101;
   localparam logic [3:0] OP_MOV = 4'b0110;

   localparam logic [1:0] SH_SLL = 2'b00;
   localparam logic [1:0] SH_SLR = 2'b01;
   localparam logic [1:0] SH_SRL = 2'b10;
   localparam logic [1:0] SH_SRA = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] work;
   logic [SHW-1:0]   cnt;
   logic [1:0]       shift_kind;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] flag_val;
   logic             alu_c;
   logic             alu_v;
   logic             use_diff;
   logic [3:0]       alu_szcv;
   logic             is_shift;
   logic             accept;

   logic [WIDTH-1:0] step_work;
   logic             step_out;

   assign is_shift = (op[3:2] == 2'b10);
   assign accept   = in_valid && in_ready;

   // Single-cycle result; also covers shift ops with zero amount (res=a, C=0).
   always_comb begin
      sum      = {1'b0, a} + {1'b0, b};
      diff     = {1'b0, a} - {1'b0, b};
      alu_res  = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      use_diff = 1'b0;
      casez (op)
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_CMP: begin
            alu_res  = a;
            use_diff = 1'b1;
            alu_c    = diff[WIDTH];
            alu_v    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_MOV:  alu_res = b;
         4'b10??: alu_res = a;
         default: alu_res = '0;
      endcase
      flag_val = use_diff ? diff[WIDTH-1:0] : alu_res;
      alu_szcv = {flag_val[WIDTH-1], (flag_val == '0), alu_c, alu_v};
   end

   always_comb begin
      step_work = work;
      step_out  = 1'b0;
      case (shift_kind)
         SH_SLL: begin
            step_work = {work[WIDTH-2:0], 1'b0};
            step_out  = work[WIDTH-1];
         end
         SH_SLR: begin
            step_work = {work[WIDTH-2:0], work[WIDTH-1]};
            step_out  = work[WIDTH-1];
         end
         SH_SRL: begin
            step_work = {1'b0, work[WIDTH-1:1]};
            step_out  = work[0];
         end
         SH_SRA: begin
            step_work = {work[WIDTH-1], work[WIDTH-1:1]};
            step_out  = work[0];
         end
         default: begin
            step_work = work;
            step_out  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         res        <= '0;
         szcv       <= 4'b0000;
         work       <= '0;
         cnt        <= '0;
         shift_kind <= SH_SLL;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  in_ready <= 1'b0;
                  if (is_shift && (shift_d != '0)) begin
                     work       <= a;
                     cnt        <= shift_d;
                     shift_kind <= op[1:0];
                     state      <= ST_SHIFT;
                  end else begin
                     res       <= alu_res;
                     szcv      <= alu_szcv;
                     out_valid <= 1'b1;
                     state     <= ST_DONE;
                  end
               end
            end
            ST_SHIFT: begin
               work <= step_work;
               cnt  <= cnt - 1'b1;
               if (cnt == SHW'(1)) begin
                  res       <= step_work;
                  szcv      <= {step_work[WIDTH-1], (step_work == '0), step_out, 1'b0};
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               // A request presented in this cycle waits for IDLE; no bypass.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_shifter_seq.sv
// tb/tb_alu_shifter_seq.sv - scoreboard bench for alu_shifter_seq at WIDTH=16 and WIDTH=8
module tb_alu_shifter_seq;

   typedef struct {
      logic [15:0] r;
      logic [3:0]  f;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_valid8;
   logic [3:0]  op;
   logic [15:0] a;
   logic [15:0] b;
   logic [3:0]  shift_d;
   logic        out_ready;

   logic        in_ready16;
   logic        out_valid16;
   logic [15:0] res16;
   logic [3:0]  szcv16;
   logic        in_ready8;
   logic        out_valid8;
   logic [7:0]  res8;
   logic [3:0]  szcv8;

   int   checks;
   int   failures;
   exp_t q16[$];
   exp_t q8[$];

   alu_shifter_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
      .op(op), .a(a), .b(b), .shift_d(shift_d),
      .out_valid(out_valid16), .out_ready(out_ready), .res(res16), .szcv(szcv16)
   );

   alu_shifter_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .op(op), .a(a[7:0]), .b(b[7:0]), .shift_d(shift_d[2:0]),
      .out_valid(out_valid8), .out_ready(out_ready), .res(res8), .szcv(szcv8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Reference built from wide integer arithmetic and whole-word shift operators.
   function automatic logic [19:0] model16(input logic [3:0] o, input logic [15:0] x,
                                           input logic [15:0] y, input logic [3:0] n);
      logic [15:0] r;
      logic [15:0] fv;
      logic        c;
      logic        v;
      int          ux, uy, sx, sy, t;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      r = '0;
      c = 1'b0;
      v = 1'b0;
      case (o)
         4'd0: begin
            r = 16'(ux + uy);
            c = (ux + uy) > 65535;
            t = sx + sy;
            v = (t > 32767) || (t < -32768);
         end
         4'd1, 4'd5: begin
            r = 16'(ux - uy);
            c = ux < uy;
            t = sx - sy;
            v = (t > 32767) || (t < -32768);
         end
         4'd2: r = x & y;
         4'd3: r = x | y;
         4'd4: r = x ^ y;
         4'd6: r = y;
         4'd8: begin
            r = x << n;
            c = (n != 0) && x[16 - int'(n)];
         end
         4'd9: begin
            r = (x << n) | (x >> (16 - int'(n)));
            c = (n != 0) && r[0];
         end
         4'd10: begin
            r = x >> n;
            c = (n != 0) && x[int'(n) - 1];
         end
         4'd11: begin
            r = $signed(x) >>> n;
            c = (n != 0) && x[int'(n) - 1];
         end
         default: r = '0;
      endcase
      fv = r;
      if (o == 4'd5) r = x;
      return {r, fv[15], (fv == 16'h0000), c, v};
   endfunction

   // Drive one request, confirm when out_valid rises (edges after the accept edge), let it retire.
   task automatic issue(input bit sel, input logic [3:0] o, input logic [15:0] aa,
                        input logic [15:0] bb, input logic [3:0] sd,
                        input logic [15:0] er, input logic [3:0] ef, input string tag);
      exp_t e;
      int   k;
      int   kexp;
      bit   rdy;
      op      = o;
      a       = aa;
      b       = bb;
      shift_d = sd;
      e.r = er;
      e.f = ef;
      kexp = ((o[3:2] == 2'b10) && (sd != 4'd0)) ? int'(sd) : 0;
      if (sel) begin
         q8.push_back(e);
         in_valid8 = 1'b1;
      end else begin
         q16.push_back(e);
         in_valid = 1'b1;
      end
      k = 0;
      rdy = sel ? in_ready8 : in_ready16;
      while (!rdy && k < 20) begin
         step();
         k++;
         rdy = sel ? in_ready8 : in_ready16;
      end
      chk({tag, "_ready"}, 32'(rdy), 32'd1);
      step();
      in_valid  = 1'b0;
      in_valid8 = 1'b0;
      a = ~aa;
      b = ~bb;
      k = 0;
      while (!(sel ? out_valid8 : out_valid16) && k < 40) begin
         chk({tag, "_busy_in_ready"}, 32'(sel ? in_ready8 : in_ready16), 32'd0);
         step();
         k++;
      end
      chk({tag, "_valid_edge"}, 32'(k), 32'(kexp));
      step();
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (out_valid16 && out_ready) begin
         if (q16.size() == 0) chk("sb16_unexpected", 32'd1, 32'd0);
         else begin
            e = q16.pop_front();
            chk("sb16_res", 32'(res16), 32'(e.r));
            chk("sb16_szcv", 32'(szcv16), 32'(e.f));
         end
      end
      if (out_valid8 && out_ready) begin
         if (q8.size() == 0) chk("sb8_unexpected", 32'd1, 32'd0);
         else begin
            e = q8.pop_front();
            chk("sb8_res", 32'(res8), 32'(e.r[7:0]));
            chk("sb8_szcv", 32'(szcv8), 32'(e.f));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  op_tab [0:13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                     4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd15};
      logic [19:0] m;
      logic [3:0]  ro;
      logic [15:0] ra, rb;
      logic [3:0]  rs;
      bit          seen_valid;

      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_valid8 = 1'b0;
      op = 4'd0;
      a = '0;
      b = '0;
      shift_d = '0;
      out_ready = 1'b1;
      repeat (2) step();
      chk("rst_out_valid", 32'(out_valid16), 32'd0);
      chk("rst_res", 32'(res16), 32'd0);
      chk("rst_szcv", 32'(szcv16), 32'd0);
      chk("rst_out_valid8", 32'(out_valid8), 32'd0);
      rst_n = 1'b1;
      step();
      chk("rst_in_ready", 32'(in_ready16), 32'd1);
      chk("rst_in_ready8", 32'(in_ready8), 32'd1);

      issue(0, 4'd0,  16'h7FFF, 16'h0001, 4'd0,  16'h8000, 4'b1001, "add_ovf");
      issue(0, 4'd1,  16'h0001, 16'h0002, 4'd0,  16'hFFFF, 4'b1010, "sub_borrow");
      issue(0, 4'd5,  16'h0005, 16'h0005, 4'd0,  16'h0005, 4'b0100, "cmp_eq");
      issue(0, 4'd1,  16'h8000, 16'h0001, 4'd0,  16'h7FFF, 4'b0001, "sub_ovf");
      issue(0, 4'd11, 16'h8001, 16'h0000, 4'd3,  16'hF000, 4'b1000, "sra3");
      issue(0, 4'd9,  16'h8001, 16'h0000, 4'd1,  16'h0003, 4'b0010, "slr1");
      issue(0, 4'd8,  16'h0001, 16'h0000, 4'd0,  16'h0001, 4'b0000, "sll0");
      issue(0, 4'd8,  16'h0001, 16'h0000, 4'd15, 16'h8000, 4'b1000, "sll15");
      issue(0, 4'd10, 16'h0003, 16'h0000, 4'd1,  16'h0001, 4'b0010, "srl1");
      issue(0, 4'd7,  16'h1234, 16'h5678, 4'd2,  16'h0000, 4'b0100, "undef7");
      issue(0, 4'd13, 16'hFFFF, 16'hFFFF, 4'd5,  16'h0000, 4'b0100, "undef13");

      issue(1, 4'd0,  16'h007F, 16'h0001, 4'd0,  16'h0080, 4'b1001, "w8_add");
      issue(1, 4'd1,  16'h0001, 16'h0002, 4'd0,  16'h00FF, 4'b1010, "w8_sub");
      issue(1, 4'd11, 16'h0081, 16'h0000, 4'd3,  16'h00F0, 4'b1000, "w8_sra3");
      issue(1, 4'd9,  16'h0081, 16'h0000, 4'd1,  16'h0003, 4'b0010, "w8_slr1");
      issue(1, 4'd10, 16'h0080, 16'h0000, 4'd7,  16'h0001, 4'b0000, "w8_srl7");

      for (int i = 0; i < 20; i++) begin
         ro = op_tab[$urandom_range(0, 13)];
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 4'($urandom_range(0, 15));
         m = model16(ro, ra, rb, rs);
         issue(0, ro, ra, rb, rs, m[19:4], m[3:0], $sformatf("rand%0d_op%0d", i, ro));
      end

      // Backpressure in DONE while a new request is already waiting.
      out_ready = 1'b0;
      op = 4'd0;
      a = 16'h1234;
      b = 16'h0001;
      shift_d = 4'd0;
      in_valid = 1'b1;
      q16.push_back('{r: 16'h1235, f: 4'b0000});
      step();
      for (int i = 0; i < 5; i++) begin
         a = 16'($urandom);
         chk("bp_res", 32'(res16), 32'h1235);
         chk("bp_szcv", 32'(szcv16), 32'd0);
         chk("bp_in_ready", 32'(in_ready16), 32'd0);
         chk("bp_out_valid", 32'(out_valid16), 32'd1);
         step();
      end
      op = 4'd6;
      b = 16'h00AB;
      q16.push_back('{r: 16'h00AB, f: 4'b0000});
      out_ready = 1'b1;
      step();
      chk("bp_retire_valid", 32'(out_valid16), 32'd0);
      chk("bp_retire_ready", 32'(in_ready16), 32'd1);
      step();
      in_valid = 1'b0;
      chk("bp_next_accept", 32'(in_ready16), 32'd0);
      chk("bp_next_valid", 32'(out_valid16), 32'd1);
      step();

      // Reset in the middle of a long shift discards the operation.
      op = 4'd10;
      a = 16'hFFFF;
      shift_d = 4'd10;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      chk("mid_busy", 32'(in_ready16), 32'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid16), 32'd0);
      chk("mid_rst_res", 32'(res16), 32'd0);
      chk("mid_rst_szcv", 32'(szcv16), 32'd0);
      step();
      rst_n = 1'b1;
      seen_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid16) seen_valid = 1'b1;
         step();
      end
      chk("mid_no_valid", 32'(seen_valid), 32'd0);
      chk("mid_idle", 32'(in_ready16), 32'd1);

      chk("q16_drained", 32'(q16.size()), 32'd0);
      chk("q8_drained", 32'(q8.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
